// File: rtl/io_pkg.sv
// Shared types and constants for the CPU In/Out/Halt responder.
package io_pkg;

  typedef enum logic [2:0] {
    StRun         = 3'd0,
    StWaitPress   = 3'd1,
    StWaitRelease = 3'd2,
    StResume      = 3'd3,
    StHalted      = 3'd4
  } io_state_e;

  localparam int unsigned DefaultDebounceCycles = 50000;

  // Active-low gfedcba patterns; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HexSegTable = {
    7'b0001110, // F
    7'b0000110, // E
    7'b0100001, // d
    7'b1000110, // C
    7'b0000011, // b
    7'b0001000, // A
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HexSegTable[nib];
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces the active-low confirm key; emits one-cycle press/release pulses.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic                 deb_q, deb_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 flip;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign flip = (sync2_q != deb_q) && (cnt_q == CntMax);

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (flip) begin
      deb_d = sync2_q;
    end else if (sync2_q != deb_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // Pulses fire in the cycle the debounced level is about to change.
  assign press_pulse   = flip && deb_q;
  assign release_pulse = flip && !deb_q;

endmodule

// File: rtl/io_handshake.sv
// Board-side responder for CPU In/Out/Halt strobes. Define IO_SEVENSEG_EN to drive
// the display as four active-low hex digits instead of the raw 28-bit register.
module io_handshake
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned SW_WIDTH        = 18
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                OpIn,
  input  logic                OpOut,
  input  logic                OpHalt,
  input  logic [31:0]         data_out,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                key_n,
  output logic                cpu_enable,
  output logic [31:0]         in_data,
  output logic [27:0]         display,
  output logic                waiting,
  output logic                halted
);

  io_state_e   state_q, state_d;
  logic [31:0] in_data_q;
  logic [27:0] display_q;
  logic        capture;
  logic        load_disp;
  logic        press_pulse;
  logic        release_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_key_debounce (
    .clock        (clock),
    .reset        (reset),
    .key_n        (key_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always_comb begin
    state_d    = state_q;
    cpu_enable = 1'b0;
    waiting    = 1'b0;
    halted     = 1'b0;
    capture    = 1'b0;
    load_disp  = 1'b0;
    unique case (state_q)
      StRun: begin
        cpu_enable = !OpIn && !OpHalt;
        if (OpHalt) begin
          state_d = StHalted;
        end else if (OpIn) begin
          state_d = StWaitPress;
        end else if (OpOut) begin
          load_disp = 1'b1;
        end
      end
      StWaitPress: begin
        waiting = 1'b1;
        if (press_pulse) begin
          capture = 1'b1;
          state_d = StWaitRelease;
        end
      end
      StWaitRelease: begin
        waiting = 1'b1;
        if (release_pulse) begin
          state_d = StResume;
        end
      end
      StResume: begin
        // OpIn is still high here; leaving unconditionally keeps it from re-triggering.
        cpu_enable = 1'b1;
        state_d    = StRun;
      end
      StHalted: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StRun;
      in_data_q <= '0;
      display_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        in_data_q <= 32'(switches);
      end
      if (load_disp) begin
        display_q <= data_out[27:0];
      end
    end
  end

  assign in_data = in_data_q;

  logic unused_data_out;
  assign unused_data_out = ^data_out[31:28];

`ifdef IO_SEVENSEG_EN
  logic unused_disp_hi;
  assign unused_disp_hi = ^display_q[27:16];

  always_comb begin
    display = '0;
    for (int d = 0; d < 4; d++) begin
      display[d*7 +: 7] = hex_to_seg(display_q[d*4 +: 4]);
    end
  end
`else
  assign display = display_q;
`endif

endmodule
